// File: rtl/prog_data_mem.sv
`default_nettype none
// ============================================================================
// Module   : prog_data_mem
// Purpose  : Combined program/data memory. Loads program bytes from switches
//            (IN), browses them (CHECK) and serves CPU accesses (RUN).
//            Optional macro PROG_SELFMOD_EN: RUN writes may modify program.
// Revision : 1.0 - initial release
// ============================================================================
module prog_data_mem #(
    parameter int DW      = 8,
    parameter int AW      = 16,
    parameter int PROG_AW = 5,
    parameter int DATA_AW = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         cpustate,
    input  logic               key_next,
    input  logic               key_prev,
    input  logic [DW-1:0]      sw,
    input  logic [AW-1:0]      addr,
    input  logic               read,
    input  logic               write,
    input  logic [DW-1:0]      data_in,
    output logic [DW-1:0]      data_out,
    output logic               data_valid,
    output logic [DW-1:0]      check_out,
    output logic [PROG_AW-1:0] ptr_out,
    output logic               prog_full,
    output logic               wr_fault
);

    localparam logic [1:0] c_mode_idle  = 2'b00;
    localparam logic [1:0] c_mode_in    = 2'b01;
    localparam logic [1:0] c_mode_check = 2'b10;
    localparam logic [1:0] c_mode_run   = 2'b11;

    localparam int c_prog_depth = 1 << PROG_AW;
    localparam int c_data_depth = 1 << DATA_AW;
    localparam int c_up_w       = AW - PROG_AW;
    localparam logic [PROG_AW-1:0] c_ptr_max  = '1;
    localparam logic [c_up_w:0]    c_data_lim = (c_up_w + 1)'(1) << DATA_AW;

    logic [DW-1:0]      r_prog [c_prog_depth];
    logic [DW-1:0]      r_data [c_data_depth];

    logic               r_next_s1, r_next_s2, r_next_d;
    logic               r_prev_s1, r_prev_s2, r_prev_d;
    logic [1:0]         r_mode, r_mode_prev;
    logic [PROG_AW-1:0] r_ptr;
    logic               r_prog_full;
    logic               r_wr_fault;
    logic [DW-1:0]      r_data_out;
    logic               r_data_valid;
    logic [DW-1:0]      r_check_out;

    logic               w_next_pulse, w_prev_pulse, w_mode_entry, w_run;
    logic [c_up_w-1:0]  w_upper;
    logic               w_in_prog, w_in_data;
    logic [PROG_AW-1:0] w_prog_idx;
    logic [DATA_AW-1:0] w_data_idx;
    logic [DW-1:0]      w_rd_data;
    logic               w_store, w_run_wr, w_data_we, w_prog_self_we, w_fault_set;
    logic               w_prog_we;
    logic [PROG_AW-1:0] w_prog_waddr;
    logic [DW-1:0]      w_prog_wdata;

    // Two-flop synchroniser plus edge register; pulse on synchronised fall.
    always_ff @(posedge clk) begin
        if (!reset) begin
            {r_next_s1, r_next_s2, r_next_d} <= 3'b111;
            {r_prev_s1, r_prev_s2, r_prev_d} <= 3'b111;
        end else begin
            {r_next_s1, r_next_s2, r_next_d} <= {key_next, r_next_s1, r_next_s2};
            {r_prev_s1, r_prev_s2, r_prev_d} <= {key_prev, r_prev_s1, r_prev_s2};
        end
    end

    assign w_next_pulse = r_next_d & ~r_next_s2;
    assign w_prev_pulse = r_prev_d & ~r_prev_s2;
    assign w_mode_entry = (r_mode != r_mode_prev);
    assign w_run        = (r_mode == c_mode_run);

    // Program region owns upper==0, so data index 0 is never reachable.
    assign w_upper    = addr[AW-1:PROG_AW];
    assign w_in_prog  = (w_upper == '0);
    assign w_in_data  = !w_in_prog && ({1'b0, w_upper} < c_data_lim);
    assign w_prog_idx = addr[PROG_AW-1:0];
    assign w_data_idx = w_upper[DATA_AW-1:0];
    assign w_rd_data  = w_in_prog ? r_prog[w_prog_idx] :
                        w_in_data ? r_data[w_data_idx] : '0;

    assign w_store   = (r_mode == c_mode_in) && !w_mode_entry && w_next_pulse && !r_prog_full;
    assign w_run_wr  = w_run && write;
    assign w_data_we = w_run_wr && w_in_data;
`ifdef PROG_SELFMOD_EN
    assign w_prog_self_we = w_run_wr && w_in_prog;
    assign w_fault_set    = w_run_wr && !w_in_data && !w_in_prog;
`else
    assign w_prog_self_we = 1'b0;
    assign w_fault_set    = w_run_wr && !w_in_data;
`endif
    assign w_prog_we    = w_store | w_prog_self_we;
    assign w_prog_waddr = w_store ? r_ptr : w_prog_idx;
    assign w_prog_wdata = w_store ? sw : data_in;

    // Storage is deliberately outside reset so contents survive it.
    always_ff @(posedge clk) begin
        if (w_prog_we) r_prog[w_prog_waddr] <= w_prog_wdata;
        if (w_data_we) r_data[w_data_idx]   <= data_in;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mode       <= c_mode_idle;
            r_mode_prev  <= c_mode_idle;
            r_ptr        <= '0;
            r_prog_full  <= 1'b0;
            r_wr_fault   <= 1'b0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_check_out  <= '0;
        end else begin
            r_mode      <= cpustate;
            r_mode_prev <= r_mode;

            if (w_mode_entry) begin
                if (r_mode == c_mode_in) begin
                    r_ptr       <= '0;
                    r_prog_full <= 1'b0;
                end else if (r_mode == c_mode_check) begin
                    r_ptr <= '0;
                end
            end else if (w_store) begin
                if (r_ptr == c_ptr_max) r_prog_full <= 1'b1;
                else                    r_ptr       <= r_ptr + PROG_AW'(1);
            end else if (r_mode == c_mode_check) begin
                if (w_next_pulse && !w_prev_pulse)      r_ptr <= r_ptr + PROG_AW'(1);
                else if (w_prev_pulse && !w_next_pulse) r_ptr <= r_ptr - PROG_AW'(1);
            end

            r_check_out <= (r_mode == c_mode_in || r_mode == c_mode_check) ? r_prog[r_ptr] : '0;

            if (w_fault_set) r_wr_fault <= 1'b1;

            if (!w_run) begin
                r_data_out   <= '0;
                r_data_valid <= 1'b0;
            end else begin
                r_data_valid <= read;
                if (read) r_data_out <= w_rd_data;
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign check_out  = r_check_out;
    assign ptr_out    = r_ptr;
    assign prog_full  = r_prog_full;
    assign wr_fault   = r_wr_fault;

endmodule
`default_nettype wire
